vga_text_engine: RTL

- Parametrised text-mode VGA pixel engine for the next-generation controller. Successor to the fixed 640x480 monochrome top level.
- Generates sync timing from parameters and walks a character buffer and a font memory through a registered 3-stage pipeline.
- Applies a per-cell 16-entry colour palette (foreground and background index) and draws a blinking hardware cursor.
- Sits between the AXI-fed buffer/font memories and the VGA PMOD pins.

---
 rtl/vga_text_engine.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/vga_text_engine.sv
// Text-mode VGA pixel engine: parametrised raster timing, character buffer and
// font walk through a fixed 3-cycle pipeline, 16-entry palette, blinking cursor.
module vga_text_engine #(
  parameter int   H_ACTIVE     = 640,
  parameter int   H_FP         = 16,
  parameter int   H_SYNC       = 96,
  parameter int   H_BP         = 48,
  parameter int   V_ACTIVE     = 480,
  parameter int   V_FP         = 10,
  parameter int   V_SYNC       = 2,
  parameter int   V_BP         = 33,
  parameter logic SYNC_POL     = 1'b0,
  parameter int   COLOR_WIDTH  = 4,
  parameter int   CHAR_W       = 8,
  parameter int   CHAR_H       = 16,
  parameter int   BLINK_FRAMES = 16,
  parameter int   N_COL        = H_ACTIVE / CHAR_W,
  parameter int   N_ROW        = V_ACTIVE / CHAR_H,
  parameter int   BUF_AW       = $clog2(N_COL * N_ROW)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  output logic [BUF_AW-1:0]             buf_addr_o,
  input  logic [15:0]                   buf_data_i,
  output logic [7+$clog2(CHAR_H)-1:0]   font_addr_o,
  input  logic [CHAR_W-1:0]             font_data_i,
  input  logic                          pal_we_i,
  input  logic [3:0]                    pal_idx_i,
  input  logic [3*COLOR_WIDTH-1:0]      pal_rgb_i,
  input  logic                          cursor_en_i,
  input  logic [6:0]                    cursor_col_i,
  input  logic [4:0]                    cursor_row_i,
  output logic [3*COLOR_WIDTH-1:0]      rgb_o,
  output logic                          hsync_o,
  output logic                          vsync_o,
  output logic                          de_o,
  output logic                          frame_start_o
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);
  localparam int CW_LOG  = $clog2(CHAR_W);
  localparam int CH_LOG  = $clog2(CHAR_H);
  localparam int RGB_W   = 3 * COLOR_WIDTH;
  localparam int FC_W    = $clog2(BLINK_FRAMES + 1);

  logic [HC_W-1:0]   hc_q;
  logic [VC_W-1:0]   vc_q;
  logic              h_last, v_last;
  logic [FC_W-1:0]   frame_cnt_q;
  logic              blink_q;
  logic [RGB_W-1:0]  pal_q [16];

  // Stage-0 combinational view of the current raster position
  logic [HC_W-1:0]   s0_col;
  logic [VC_W-1:0]   s0_row;
  logic [CW_LOG-1:0] s0_xoff;
  logic [CH_LOG-1:0] s0_grow;
  logic              s0_de, s0_hs, s0_vs, s0_fs, s0_cur;
  logic [BUF_AW-1:0] s0_addr;

  // Stage-1: buffer read in flight
  logic              s1_de_q, s1_hs_q, s1_vs_q, s1_fs_q, s1_cur_q;
  logic [CW_LOG-1:0] s1_xoff_q;
  logic [CH_LOG-1:0] s1_grow_q;

  // Stage-2: font read in flight, colour indices known
  logic              s2_de_q, s2_hs_q, s2_vs_q, s2_fs_q;
  logic [CW_LOG-1:0] s2_xoff_q;
  logic [3:0]        s2_fg_q, s2_bg_q;
  logic              s2_pix;
  logic [3:0]        s2_idx;

  // Stage-3: output registers
  logic [RGB_W-1:0]  rgb_q;
  logic              de_q, hs_q, vs_q, fs_q;

  // Bit 7 of a cell carries no meaning for this engine.
  logic unused_cell_bit;
  assign unused_cell_bit = buf_data_i[7];

  assign h_last = (32'(hc_q) == H_TOTAL - 1);
  assign v_last = (32'(vc_q) == V_TOTAL - 1);

  // Raster counters: pixel within line, then line within frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hc_q <= '0;
      vc_q <= '0;
    end else if (h_last) begin
      hc_q <= '0;
      vc_q <= v_last ? '0 : vc_q + VC_W'(1);
    end else begin
      hc_q <= hc_q + HC_W'(1);
    end
  end

  // Cursor blink: phase flips once every BLINK_FRAMES frames.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (h_last && v_last) begin
      if (32'(frame_cnt_q) == BLINK_FRAMES - 1) begin
        frame_cnt_q <= '0;
        blink_q     <= ~blink_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + FC_W'(1);
      end
    end
  end

  // Stage 0: decode position into cell address, timing flags and cursor hit.
  always_comb begin
    s0_col  = hc_q >> CW_LOG;
    s0_row  = vc_q >> CH_LOG;
    s0_xoff = hc_q[CW_LOG-1:0];
    s0_grow = vc_q[CH_LOG-1:0];
    s0_de   = (32'(hc_q) < H_ACTIVE) && (32'(vc_q) < V_ACTIVE);
    s0_hs   = (32'(hc_q) >= H_ACTIVE + H_FP) && (32'(hc_q) < H_ACTIVE + H_FP + H_SYNC);
    s0_vs   = (32'(vc_q) >= V_ACTIVE + V_FP) && (32'(vc_q) < V_ACTIVE + V_FP + V_SYNC);
    s0_fs   = (hc_q == '0) && (vc_q == '0);
    s0_cur  = cursor_en_i && blink_q && s0_de
              && (32'(cursor_col_i) < N_COL) && (32'(cursor_row_i) < N_ROW)
              && (32'(cursor_col_i) == 32'(s0_col))
              && (32'(cursor_row_i) == 32'(s0_row))
              && (32'(s0_grow) >= CHAR_H - 2);
    // Blanking parks the address at cell 0 so it never leaves the buffer.
    s0_addr = s0_de ? BUF_AW'(32'(s0_row) * N_COL + 32'(s0_col)) : '0;
  end

  assign buf_addr_o = s0_addr;

  // Stage 1: hold position context while the cell is read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_de_q   <= 1'b0;
      s1_hs_q   <= 1'b0;
      s1_vs_q   <= 1'b0;
      s1_fs_q   <= 1'b0;
      s1_cur_q  <= 1'b0;
      s1_xoff_q <= '0;
      s1_grow_q <= '0;
    end else begin
      s1_de_q   <= s0_de;
      s1_hs_q   <= s0_hs;
      s1_vs_q   <= s0_vs;
      s1_fs_q   <= s0_fs;
      s1_cur_q  <= s0_cur;
      s1_xoff_q <= s0_xoff;
      s1_grow_q <= s0_grow;
    end
  end

  assign font_addr_o = {buf_data_i[6:0], s1_grow_q};

  // Stage 2: latch colour indices, swapping them under the cursor.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_de_q   <= 1'b0;
      s2_hs_q   <= 1'b0;
      s2_vs_q   <= 1'b0;
      s2_fs_q   <= 1'b0;
      s2_xoff_q <= '0;
      s2_fg_q   <= '0;
      s2_bg_q   <= '0;
    end else begin
      s2_de_q   <= s1_de_q;
      s2_hs_q   <= s1_hs_q;
      s2_vs_q   <= s1_vs_q;
      s2_fs_q   <= s1_fs_q;
      s2_xoff_q <= s1_xoff_q;
      s2_fg_q   <= s1_cur_q ? buf_data_i[15:12] : buf_data_i[11:8];
      s2_bg_q   <= s1_cur_q ? buf_data_i[11:8]  : buf_data_i[15:12];
    end
  end

  // Glyph bit selects foreground or background; MSB is the leftmost pixel.
  always_comb begin
    s2_pix = font_data_i[CW_LOG'(CHAR_W - 1) - s2_xoff_q];
    s2_idx = s2_pix ? s2_fg_q : s2_bg_q;
  end

  // Palette: read combinationally, so a same-cycle write is seen one cycle later.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 16; i++) begin
        pal_q[i] <= (i == 0) ? {RGB_W{1'b0}} : {RGB_W{1'b1}};
      end
    end else if (pal_we_i) begin
      pal_q[pal_idx_i] <= pal_rgb_i;
    end
  end

  // Stage 3: aligned output registers; colour is blanked outside active video.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rgb_q <= '0;
      de_q  <= 1'b0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      fs_q  <= 1'b0;
    end else begin
      rgb_q <= s2_de_q ? pal_q[s2_idx] : '0;
      de_q  <= s2_de_q;
      hs_q  <= s2_hs_q ? SYNC_POL : ~SYNC_POL;
      vs_q  <= s2_vs_q ? SYNC_POL : ~SYNC_POL;
      fs_q  <= s2_fs_q;
    end
  end

  assign rgb_o         = rgb_q;
  assign de_o          = de_q;
  assign hsync_o       = hs_q;
  assign vsync_o       = vs_q;
  assign frame_start_o = fs_q;

endmodule
